// File: rtl/pcpi_approx_mac.sv
// pcpi_approx_mac: PCPI coprocessor that sums the four 8x8 lane products of an
// external approximate SIMD multiplier into a 32-bit internal accumulator.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   pcpi_valid       core requests a coprocessor instruction
//   pcpi_insn        instruction word (custom-0 opcode, funct7 = FUNCT7)
//   pcpi_rs1/rs2     source operands
//   pcpi_wr          write pcpi_rd to the destination register (one-cycle pulse)
//   pcpi_rd          result, holds its last value outside the ready pulse
//   pcpi_wait        instruction claimed, result pending (MAC lane cycles)
//   pcpi_ready       result valid, one-cycle pulse
//   mul_a/mul_b      latched rs1/rs2; byte k feeds multiplier lane k
//   mul_prod         lane products, lane k at [16k+15:16k], combinational from mul_a/mul_b
//
// funct3: 000 MAC, 001 READ, 010 CLEAR, 011 SET. Other funct3/funct7 are not claimed.

module pcpi_approx_mac #(
  parameter bit         ACC_SAT = 1'b0,
  parameter logic [6:0] FUNCT7  = 7'b000_0011
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_prod
);

  typedef enum logic [1:0] {StIdle, StLane, StDone, StCool} state_e;

  localparam logic [1:0] OpMac   = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpClear = 2'b10;
  localparam logic [1:0] OpSet   = 2'b11;

  state_e      state;
  logic [1:0]  lane;
  logic [31:0] acc;

  logic        insn_match;
  logic [15:0] lane_prod;
  logic [32:0] acc_sum;
  logic [31:0] acc_next;

  // Register/immediate fields of the instruction carry no meaning here.
  logic unused_insn;
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // funct3[2] must be clear; the low two bits then select one of four ops.
  assign insn_match = pcpi_valid
                    && (pcpi_insn[6:0] == 7'b000_1011)
                    && (pcpi_insn[31:25] == FUNCT7)
                    && !pcpi_insn[14];

  always_comb begin
    lane_prod = 16'h0000;
    unique case (lane)
      2'd0: lane_prod = mul_prod[15:0];
      2'd1: lane_prod = mul_prod[31:16];
      2'd2: lane_prod = mul_prod[47:32];
      2'd3: lane_prod = mul_prod[63:48];
      default: lane_prod = 16'h0000;
    endcase
  end

  // A carry out of bit 31 means the true sum exceeds 32 bits; once clamped at
  // all-ones every further add carries again, so saturation is sticky.
  always_comb begin
    acc_sum  = {1'b0, acc} + {17'b0, lane_prod};
    acc_next = (ACC_SAT && acc_sum[32]) ? 32'hFFFF_FFFF : acc_sum[31:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= StIdle;
      lane       <= 2'd0;
      acc        <= 32'h0;
      mul_a      <= 32'h0;
      mul_b      <= 32'h0;
      pcpi_rd    <= 32'h0;
      pcpi_wr    <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wait  <= 1'b0;
    end else begin
      pcpi_wr    <= 1'b0;
      pcpi_ready <= 1'b0;
      unique case (state)
        StIdle: begin
          if (insn_match) begin
            mul_a <= pcpi_rs1;
            mul_b <= pcpi_rs2;
            lane  <= 2'd0;
            unique case (pcpi_insn[13:12])
              OpMac: begin
                state     <= StLane;
                pcpi_wait <= 1'b1;
              end
              OpRead: begin
                state      <= StDone;
                pcpi_rd    <= acc;
                pcpi_wr    <= 1'b1;
                pcpi_ready <= 1'b1;
              end
              OpClear: begin
                state      <= StDone;
                pcpi_rd    <= acc;
                acc        <= 32'h0;
                pcpi_wr    <= 1'b1;
                pcpi_ready <= 1'b1;
              end
              OpSet: begin
                state      <= StDone;
                pcpi_rd    <= pcpi_rs1;
                acc        <= pcpi_rs1;
                pcpi_wr    <= 1'b1;
                pcpi_ready <= 1'b1;
              end
              default: state <= StIdle;
            endcase
          end
        end
        StLane: begin
          acc  <= acc_next;
          lane <= lane + 2'd1;
          if (lane == 2'd3) begin
            state      <= StDone;
            pcpi_wait  <= 1'b0;
            pcpi_rd    <= acc_next;
            pcpi_wr    <= 1'b1;
            pcpi_ready <= 1'b1;
          end
        end
        StDone: state <= StCool;
        // The core may still hold pcpi_valid for the finished instruction.
        StCool: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_approx_mac.sv
// Self-checking bench for pcpi_approx_mac. Two instances run in lockstep, one
// wrapping (ACC_SAT=0) and one saturating (ACC_SAT=1), each fed by an exact
// 4-lane multiplier model.

module tb_pcpi_approx_mac;

  localparam logic [6:0] F7 = 7'b000_0011;

  logic        clk;
  logic        resetn;
  logic        valid;
  logic [31:0] insn;
  logic [31:0] rs1;
  logic [31:0] rs2;

  logic        wr    [2];
  logic [31:0] rd    [2];
  logic        waitq [2];
  logic        ready [2];
  logic [31:0] mul_a [2];
  logic [31:0] mul_b [2];
  logic [63:0] mul_prod [2];

  // Reference state, per instance
  logic [31:0] m_acc [2];
  logic [31:0] m_rd  [2];
  logic [31:0] m_a;
  logic [31:0] m_b;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [63:0] exact_lanes(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    for (int k = 0; k < 4; k++) p[16*k +: 16] = 16'(a[8*k +: 8]) * 16'(b[8*k +: 8]);
    return p;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pcpi_approx_mac #(
      .ACC_SAT(g == 1),
      .FUNCT7 (F7)
    ) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .pcpi_valid(valid),
      .pcpi_insn (insn),
      .pcpi_rs1  (rs1),
      .pcpi_rs2  (rs2),
      .pcpi_wr   (wr[g]),
      .pcpi_rd   (rd[g]),
      .pcpi_wait (waitq[g]),
      .pcpi_ready(ready[g]),
      .mul_a     (mul_a[g]),
      .mul_b     (mul_b[g]),
      .mul_prod  (mul_prod[g])
    );
    assign mul_prod[g] = exact_lanes(mul_a[g], mul_b[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, required %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] make_insn(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 10'b0, f3, 5'd1, 7'b000_1011};
  endfunction

  // Accumulate the four exact lane products, lane by lane, in wide arithmetic.
  function automatic logic [31:0] model_mac(input logic [31:0] acc, input logic [31:0] a,
                                            input logic [31:0] b, input bit sat);
    longint s = longint'(acc);
    for (int k = 0; k < 4; k++) begin
      s = s + longint'(a[8*k +: 8]) * longint'(b[8*k +: 8]);
      if (s > 64'hFFFF_FFFF) s = sat ? 64'hFFFF_FFFF : (s & 64'hFFFF_FFFF);
    end
    return s[31:0];
  endfunction

  task automatic check_idle_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      check_eq({tag, "_ready"}, ready[g], 1'b0);
      check_eq({tag, "_wr"}, wr[g], 1'b0);
      check_eq({tag, "_wait"}, waitq[g], 1'b0);
      check_eq({tag, "_rd"}, rd[g], m_rd[g]);
    end
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit hold);
    int lat = (f3 == 3'd0) ? 5 : 1;
    int got = 0;
    for (int g = 0; g < 2; g++) begin
      case (f3)
        3'd0: begin m_acc[g] = model_mac(m_acc[g], a, b, g == 1); m_rd[g] = m_acc[g]; end
        3'd1: m_rd[g] = m_acc[g];
        3'd2: begin m_rd[g] = m_acc[g]; m_acc[g] = 32'h0; end
        default: begin m_acc[g] = a; m_rd[g] = a; end
      endcase
    end
    m_a = a;
    m_b = b;
    @(negedge clk);
    valid = 1'b1;
    insn  = make_insn(F7, f3);
    rs1   = a;
    rs2   = b;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (!hold) valid = 1'b0;
      rs1 = $urandom;
      rs2 = $urandom;
      if (ready[0]) begin
        got = c;
        break;
      end
      for (int g = 0; g < 2; g++) begin
        check_eq("lane_wait", waitq[g], 1'b1);
        check_eq("lane_wr", wr[g], 1'b0);
      end
    end
    check_eq("latency", 32'(got), 32'(lat));
    for (int g = 0; g < 2; g++) begin
      check_eq("done_ready", ready[g], 1'b1);
      check_eq("done_wr", wr[g], 1'b1);
      check_eq("done_wait", waitq[g], 1'b0);
      check_eq("done_rd", rd[g], m_rd[g]);
      check_eq("mul_a", mul_a[g], m_a);
      check_eq("mul_b", mul_b[g], m_b);
    end
    @(negedge clk);
    if (!hold) valid = 1'b0;
    check_idle_outputs("cool");
    if (hold) begin
      @(negedge clk);
      valid = 1'b0;
      check_idle_outputs("held");
    end
  endtask

  task automatic do_bad(input logic [6:0] f7, input logic [2:0] f3);
    @(negedge clk);
    valid = 1'b1;
    insn  = make_insn(f7, f3);
    rs1   = $urandom;
    rs2   = $urandom;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) begin
      check_idle_outputs("unmatched");
      for (int g = 0; g < 2; g++) check_eq("unmatched_mul_a", mul_a[g], m_a);
      @(negedge clk);
    end
  endtask

  initial begin
    resetn = 1'b1;
    valid  = 1'b0;
    insn   = 32'h0;
    rs1    = 32'h0;
    rs2    = 32'h0;
    for (int g = 0; g < 2; g++) begin m_acc[g] = 32'h0; m_rd[g] = 32'h0; end
    m_a = 32'h0;
    m_b = 32'h0;
    #3 resetn = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    for (int g = 0; g < 2; g++) begin
      check_eq("reset_mul_a", mul_a[g], 32'h0);
      check_eq("reset_mul_b", mul_b[g], 32'h0);
    end
    resetn = 1'b1;

    do_op(3'd2, 32'h0, 32'h0, 1'b0);
    do_op(3'd0, 32'h0102_0304, 32'h0506_0708, 1'b0);
    check_eq("plan_mac1", rd[0], 32'h0000_0046);
    do_op(3'd0, 32'h0102_0304, 32'h0506_0708, 1'b0);
    check_eq("plan_mac2", rd[0], 32'h0000_008C);
    do_op(3'd1, 32'h0, 32'h0, 1'b0);
    check_eq("plan_read", rd[1], 32'h0000_008C);

    do_op(3'd3, 32'hFFFF_FF00, 32'h0, 1'b0);
    do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_eq("plan_wrap", rd[0], 32'h0003_F704);
    check_eq("plan_sat", rd[1], 32'hFFFF_FFFF);

    do_bad(7'b000_0010, 3'd0);
    do_bad(F7, 3'b100);
    do_op(3'd1, 32'h0, 32'h0, 1'b0);

    do_op(3'd3, 32'h0000_1000, 32'h0, 1'b0);
    do_op(3'd0, 32'h0102_0304, 32'h0506_0708, 1'b1);
    do_op(3'd1, 32'h0, 32'h0, 1'b0);
    check_eq("plan_hold", rd[0], 32'h0000_1046);

    // Reset in the middle of a MAC.
    @(negedge clk);
    valid = 1'b1;
    insn  = make_insn(F7, 3'd0);
    rs1   = 32'h1111_1111;
    rs2   = 32'h2222_2222;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin m_acc[g] = 32'h0; m_rd[g] = 32'h0; end
    m_a = 32'h0;
    m_b = 32'h0;
    check_idle_outputs("midreset");
    for (int g = 0; g < 2; g++) check_eq("midreset_mul_a", mul_a[g], 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    do_op(3'd1, 32'h0, 32'h0, 1'b0);
    check_eq("plan_reset_read", rd[0], 32'h0);

    for (int i = 0; i < 60; i++) begin
      int unsigned sel = $urandom_range(0, 5);
      if (sel == 5) begin
        if ($urandom_range(0, 1) == 1) do_bad(F7, 3'(4 + $urandom_range(0, 3)));
        else do_bad(7'(F7 ^ 7'($urandom_range(1, 127))), 3'($urandom_range(0, 3)));
      end else if (sel == 4) begin
        do_op(3'd3, ($urandom_range(0, 1) == 1) ? 32'hFFFF_0000 | $urandom : $urandom,
              32'h0, 1'b0);
      end else begin
        do_op(3'(sel), $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
